// File: rtl/clk_pkg.sv
// Shared types and constants for the BCD real-time clock with alarm.
package clk_pkg;

    typedef logic [3:0] bcd_t;

    localparam int HOUR_WRAP  = 23;
    localparam int MIN_WRAP   = 59;
    localparam int SEC_WRAP   = 59;
    localparam int H12_OFFSET = 12;

    typedef enum logic [1:0] {SEL_NONE, SEL_HOUR, SEL_MIN, SEL_SEC} sel_e;

    function automatic logic [4:0] hour_bin(input bcd_t t, input bcd_t u);
        return {1'b0, t} * 5'd10 + {1'b0, u};
    endfunction

    // Folds a 0..23 hour onto the 1..12 face; pm is derived separately.
    function automatic logic [4:0] to_12h(input logic [4:0] h);
        if (h == 5'd0)
            return 5'(H12_OFFSET);
        else if (h > 5'(H12_OFFSET))
            return h - 5'(H12_OFFSET);
        else
            return h;
    endfunction

    function automatic logic [7:0] hour_bcd(input logic [4:0] h);
        logic [4:0] r;
        bcd_t       t;
        if (h >= 5'd20) begin
            t = 4'd2;
            r = h - 5'd20;
        end else if (h >= 5'd10) begin
            t = 4'd1;
            r = h - 5'd10;
        end else begin
            t = 4'd0;
            r = h;
        end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/bcd_field_cnt.sv
// Tens/units BCD field register that increments and wraps at MAX_T:MAX_U.
module bcd_field_cnt
    import clk_pkg::*;
#(
    parameter int MAX_T = 5,
    parameter int MAX_U = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output bcd_t t,
    output bcd_t u,
    output bcd_t nxt_t,
    output bcd_t nxt_u,
    output logic carry_out
);

    localparam bcd_t MT = bcd_t'(MAX_T);
    localparam bcd_t MU = bcd_t'(MAX_U);

    // Units roll at 9 except on the top tens digit, which also covers 23 for hours.
    always_comb begin
        carry_out = (t == MT) && (u == MU);
        nxt_t     = t;
        nxt_u     = u + 4'd1;
        if (carry_out) begin
            nxt_t = 4'd0;
            nxt_u = 4'd0;
        end else if (u == 4'd9) begin
            nxt_t = t + 4'd1;
            nxt_u = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= 4'd0;
            u <= 4'd0;
        end else if (inc) begin
            t <= nxt_t;
            u <= nxt_u;
        end
    end

endmodule

// File: rtl/rtc_bcd_alarm.sv
// BCD time-of-day clock with prescaler, per-field set mode, 12/24h display
// and an hh:mm alarm with ring timeout and acknowledge.
module rtc_bcd_alarm
    import clk_pkg::*;
#(
    parameter  int CLK_HZ   = 1000,
    parameter  int RING_SEC = 60,
    localparam int PW       = $clog2(CLK_HZ)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic       set_alm,
    input  logic       sel_hour,
    input  logic       sel_min,
    input  logic       sel_sec,
    input  logic       set_inc,
    input  logic       mode12,
    input  logic       alm_en,
    input  logic       alm_ack,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       pm,
    output logic       sec_tick,
    output logic       alarm_ring
);

    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam int            RW      = $clog2(RING_SEC + 1);
    localparam logic [RW-1:0] RING_LD = RW'(RING_SEC);

    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] ring_cnt;
    logic          tick, inc_prev, set_rise, trigger;
    sel_e          sel;

    bcd_t th_t, th_u, tm_t, tm_u, ts_t, ts_u;
    bcd_t th_nt, th_nu, tm_nt, tm_nu, ts_nt, ts_nu;
    bcd_t ah_t, ah_u, am_t, am_u;
    bcd_t ah_nt, ah_nu, am_nt, am_nu;
    logic th_cy, tm_cy, ts_cy, ah_cy, am_cy;
    logic ts_inc, tm_inc, th_inc, am_inc, ah_inc;

    // Prescaler is parked at 0 in set mode so a full second follows release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pre_cnt <= '0;
        else if (set_en || pre_cnt == PRE_MAX)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = !set_en && (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_tick <= 1'b0;
            inc_prev <= 1'b0;
        end else begin
            sec_tick <= tick;
            inc_prev <= set_inc;
        end
    end

    assign set_rise = set_en && set_inc && !inc_prev;

    always_comb begin
        sel = SEL_NONE;
        if (sel_hour)
            sel = SEL_HOUR;
        else if (sel_min)
            sel = SEL_MIN;
        else if (sel_sec)
            sel = SEL_SEC;
    end

    // Manual edits never carry; ticks ripple through the carry chain.
    always_comb begin
        ts_inc = tick || (set_rise && !set_alm && sel == SEL_SEC);
        tm_inc = (tick && ts_cy) || (set_rise && !set_alm && sel == SEL_MIN);
        th_inc = (tick && ts_cy && tm_cy) || (set_rise && !set_alm && sel == SEL_HOUR);
        am_inc = set_rise && set_alm && sel == SEL_MIN;
        ah_inc = set_rise && set_alm && sel == SEL_HOUR;
    end

    bcd_field_cnt #(.MAX_T(SEC_WRAP / 10), .MAX_U(SEC_WRAP % 10)) u_sec (
        .clk(clk), .rst(rst), .inc(ts_inc), .t(ts_t), .u(ts_u),
        .nxt_t(ts_nt), .nxt_u(ts_nu), .carry_out(ts_cy)
    );

    bcd_field_cnt #(.MAX_T(MIN_WRAP / 10), .MAX_U(MIN_WRAP % 10)) u_min (
        .clk(clk), .rst(rst), .inc(tm_inc), .t(tm_t), .u(tm_u),
        .nxt_t(tm_nt), .nxt_u(tm_nu), .carry_out(tm_cy)
    );

    bcd_field_cnt #(.MAX_T(HOUR_WRAP / 10), .MAX_U(HOUR_WRAP % 10)) u_hour (
        .clk(clk), .rst(rst), .inc(th_inc), .t(th_t), .u(th_u),
        .nxt_t(th_nt), .nxt_u(th_nu), .carry_out(th_cy)
    );

    bcd_field_cnt #(.MAX_T(MIN_WRAP / 10), .MAX_U(MIN_WRAP % 10)) u_alm_min (
        .clk(clk), .rst(rst), .inc(am_inc), .t(am_t), .u(am_u),
        .nxt_t(am_nt), .nxt_u(am_nu), .carry_out(am_cy)
    );

    bcd_field_cnt #(.MAX_T(HOUR_WRAP / 10), .MAX_U(HOUR_WRAP % 10)) u_alm_hour (
        .clk(clk), .rst(rst), .inc(ah_inc), .t(ah_t), .u(ah_u),
        .nxt_t(ah_nt), .nxt_u(ah_nu), .carry_out(ah_cy)
    );

    logic unused_ok;
    assign unused_ok = ^{th_cy, ah_cy, am_cy, ah_nt, ah_nu, am_nt, am_nu, ts_nt, ts_nu};

    // Match against the post-tick time so the ring asserts right after the tick.
    always_comb begin
        bcd_t nh_t, nh_u;
        nh_t = tm_cy ? th_nt : th_t;
        nh_u = tm_cy ? th_nu : th_u;
        trigger = tick && ts_cy && alm_en
                  && ({tm_nt, tm_nu} == {am_t, am_u})
                  && ({nh_t, nh_u} == {ah_t, ah_u});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else if (alm_ack || !alm_en) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else if (trigger) begin
            alarm_ring <= 1'b1;
            ring_cnt   <= RING_LD;
        end else if (tick && alarm_ring) begin
            ring_cnt <= ring_cnt - 1'b1;
            if (ring_cnt == RW'(1))
                alarm_ring <= 1'b0;
        end
    end

    always_comb begin
        logic       disp_alm;
        logic [4:0] h_bin;
        bcd_t       dh_t, dh_u;
        disp_alm       = set_en && set_alm;
        dh_t           = disp_alm ? ah_t : th_t;
        dh_u           = disp_alm ? ah_u : th_u;
        h_bin          = hour_bin(dh_t, dh_u);
        pm             = (h_bin >= 5'(H12_OFFSET));
        {hr_t, hr_u}   = hour_bcd(mode12 ? to_12h(h_bin) : h_bin);
        {min_t, min_u} = disp_alm ? {am_t, am_u} : {tm_t, tm_u};
        {sec_t, sec_u} = disp_alm ? 8'h00 : {ts_t, ts_u};
    end

endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// Randomised and directed bench for rtc_bcd_alarm against a seconds-of-day model.
module tb_rtc_bcd_alarm;

    localparam int HZ = 10;
    localparam int RS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_en = 0, set_alm = 0, sel_hour = 0, sel_min = 0, sel_sec = 0;
    logic set_inc = 0, mode12 = 0, alm_en = 0, alm_ack = 0;
    logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
    logic pm, sec_tick, alarm_ring;

    int total = 0, bad = 0;
    int tick_seen;

    // Model state: time as seconds of day, alarm as minutes of day.
    int m_tod, m_alm, m_pre, m_left;
    bit m_ring, m_tq, m_prev;

    always #5 clk = ~clk;

    rtc_bcd_alarm #(.CLK_HZ(HZ), .RING_SEC(RS)) dut (
        .clk(clk), .rst(rst), .set_en(set_en), .set_alm(set_alm),
        .sel_hour(sel_hour), .sel_min(sel_min), .sel_sec(sel_sec),
        .set_inc(set_inc), .mode12(mode12), .alm_en(alm_en), .alm_ack(alm_ack),
        .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
        .sec_t(sec_t), .sec_u(sec_u), .pm(pm), .sec_tick(sec_tick),
        .alarm_ring(alarm_ring)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] digits();
        return {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
    endfunction

    task automatic model_reset();
        m_tod = 0; m_alm = 0; m_pre = 0; m_left = 0;
        m_ring = 0; m_tq = 0; m_prev = 0;
    endtask

    task automatic model_step();
        bit rise, tick, trig;
        int k, h, mi, s;
        rise   = set_inc && !m_prev;
        m_prev = set_inc;
        tick   = !set_en && (m_pre == HZ - 1);
        m_pre  = set_en ? 0 : (m_pre + 1) % HZ;
        trig   = 0;
        if (tick) begin
            m_tod = (m_tod + 1) % 86400;
            trig  = alm_en && (m_tod == m_alm * 60);
        end
        if (set_en && rise) begin
            k  = sel_hour ? 1 : sel_min ? 2 : sel_sec ? 3 : 0;
            h  = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
            if (set_alm) begin
                if (k == 1) m_alm = ((m_alm / 60 + 1) % 24) * 60 + m_alm % 60;
                if (k == 2) m_alm = (m_alm / 60) * 60 + (m_alm % 60 + 1) % 60;
            end else begin
                if (k == 1) h = (h + 1) % 24;
                if (k == 2) mi = (mi + 1) % 60;
                if (k == 3) s = (s + 1) % 60;
                m_tod = h * 3600 + mi * 60 + s;
            end
        end
        if (alm_ack || !alm_en) begin
            m_ring = 0; m_left = 0;
        end else if (trig) begin
            m_ring = 1; m_left = RS;
        end else if (tick && m_ring) begin
            m_left--;
            if (m_left == 0) m_ring = 0;
        end
        m_tq = tick;
    endtask

    task automatic check_all(input string tag);
        bit da;
        int h, mi, s, hd;
        da = set_en && set_alm;
        h  = da ? m_alm / 60 : m_tod / 3600;
        mi = da ? m_alm % 60 : (m_tod / 60) % 60;
        s  = da ? 0 : m_tod % 60;
        hd = !mode12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        chk({tag, "_dig"}, digits(), {bcd8(hd), bcd8(mi), bcd8(s)});
        chk({tag, "_pm"}, pm, h >= 12);
        chk({tag, "_tick"}, sec_tick, m_tq);
        chk({tag, "_ring"}, alarm_ring, m_ring);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        if (sec_tick) tick_seen++;
        check_all("cyc");
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press();
        set_inc = 1; step();
        set_inc = 0; step();
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        int n;
        set_en = 1; set_alm = 0; sel_hour = 0; sel_min = 0; sel_sec = 0;
        sel_hour = 1; n = (h - m_tod / 3600 + 24) % 24;          repeat (n) press(); sel_hour = 0;
        sel_min  = 1; n = (mi - (m_tod / 60) % 60 + 60) % 60;    repeat (n) press(); sel_min = 0;
        sel_sec  = 1; n = (s - m_tod % 60 + 60) % 60;            repeat (n) press(); sel_sec = 0;
    endtask

    task automatic set_alarm(input int h, input int mi);
        int n;
        set_en = 1; set_alm = 1; sel_hour = 0; sel_min = 0; sel_sec = 0;
        sel_hour = 1; n = (h - m_alm / 60 + 24) % 24;  repeat (n) press(); sel_hour = 0;
        sel_min  = 1; n = (mi - m_alm % 60 + 60) % 60; repeat (n) press(); sel_min = 0;
        set_alm = 0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1;
        #1;
        model_reset();
        chk({tag, "_dig"}, digits(), 24'h000000);
        chk({tag, "_pm"}, pm, 1'b0);
        chk({tag, "_tick"}, sec_tick, 1'b0);
        chk({tag, "_ring"}, alarm_ring, 1'b0);
        set_en = 0; set_alm = 0; sel_hour = 0; sel_min = 0; sel_sec = 0;
        set_inc = 0; alm_ack = 0; alm_en = 0; mode12 = 0;
        run(2);
        rst = 0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_dig", digits(), 24'h000000);
        chk("rst_pm", pm, 1'b0);
        chk("rst_tick", sec_tick, 1'b0);
        chk("rst_ring", alarm_ring, 1'b0);
        mode12 = 1; #1;
        chk("rst_dig12", digits(), 24'h120000);
        mode12 = 0;
        @(negedge clk) rst = 0;

        tick_seen = 0;
        run(10);
        chk("first_secu", sec_u, 4'd1);
        chk("first_ticks", tick_seen, 1);
        mode12 = 1; #1;
        chk("first_dig12", digits(), 24'h120001);
        chk("first_pm", pm, 1'b0);
        mode12 = 0;

        set_time(23, 59, 59); set_en = 0; run(10);
        chk("roll_day", digits(), 24'h000000);
        chk("roll_day_pm", pm, 1'b0);
        set_time(12, 59, 59); set_en = 0; run(10);
        chk("roll_13", digits(), 24'h130000);
        chk("roll_13_pm", pm, 1'b1);
        mode12 = 1; #1;
        chk("roll_13_12h", digits(), 24'h010000);
        mode12 = 0;

        set_time(13, 57, 0);
        sel_min = 1;
        repeat (5) press();
        chk("nocarry", digits(), 24'h130200);
        tick_seen = 0;
        set_inc = 1; run(20); set_inc = 0; step();
        chk("hold_once", digits(), 24'h130300);
        chk("hold_noticks", tick_seen, 0);
        sel_min = 0; set_en = 0;
        run(9);
        chk("release_9", sec_u, 4'd0);
        step();
        chk("release_10", sec_u, 4'd1);
        chk("release_tick", sec_tick, 1'b1);

        set_en = 1; sel_hour = 1; sel_min = 1;
        press();
        chk("prio_hour", digits(), 24'h140301);
        sel_hour = 0; sel_min = 0;
        set_alm = 1; sel_sec = 1;
        press();
        chk("alm_secsel", digits(), 24'h000000);
        sel_sec = 0; set_alm = 0;

        set_alarm(0, 1); set_time(0, 0, 59); alm_en = 1; set_en = 0;
        run(10);
        chk("alm_ring", alarm_ring, 1'b1);
        chk("alm_dig", digits(), 24'h000100);
        run(29);
        chk("alm_hold", alarm_ring, 1'b1);
        step();
        chk("alm_timeout", alarm_ring, 1'b0);

        set_time(0, 0, 59); set_en = 0;
        run(9);
        alm_ack = 1; step(); alm_ack = 0;
        chk("ack_vs_trig", alarm_ring, 1'b0);
        run(3);
        chk("ack_stays", alarm_ring, 1'b0);

        set_time(0, 0, 59); set_en = 0; run(10);
        chk("ring_again", alarm_ring, 1'b1);
        async_reset("rst_ring");

        set_alarm(5, 5); set_en = 1; set_alm = 1;
        chk("alm_edit_dig", digits(), 24'h050500);
        async_reset("rst_set");

        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            mode12 = 1'($urandom_range(0, 1));
            case (r)
                0, 1, 2, 3: begin set_en = 0; run($urandom_range(1, 25)); end
                4: begin
                    set_en = 1; set_alm = 1'($urandom_range(0, 1));
                    sel_hour = 1'($urandom_range(0, 1)); sel_min = 1'($urandom_range(0, 1));
                    sel_sec = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 4)) press();
                    sel_hour = 0; sel_min = 0; sel_sec = 0; set_alm = 0;
                    set_en = 1'($urandom_range(0, 1));
                end
                5: alm_en = ~alm_en;
                6: begin alm_ack = 1; step(); alm_ack = 0; end
                7: begin
                    int h, mi;
                    h = $urandom_range(0, 23); mi = $urandom_range(0, 58);
                    set_alarm(h, mi + 1);
                    set_time(h, mi, $urandom_range(55, 59));
                    set_en = 0; alm_en = 1;
                end
                8: begin
                    set_en = 0; set_inc = 1; run(2);
                    set_en = 1; run(2);
                    set_inc = 0; set_en = 0; step();
                end
                default: begin set_en = 0; run(40); end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
